// File: rtl/lcd1602_bus_ctrl_if.sv
// Bus bundle for lcd1602_bus_ctrl: CPU-side write FIFO port plus the LCD1602 header pins.
// The master modport is the environment (CPU decode + LCD pads); slave is the controller.
interface lcd1602_bus_ctrl_if;
    logic       wr_stb;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       full;
    logic       busy;
    logic       ovf;
    logic       lcd_e;
    logic       lcd_rw;
    logic       lcd_rs;
    logic [7:0] lcd_d_out;
    logic       lcd_d_oe;
    logic [7:0] lcd_d_in;

    modport master (
        output wr_stb, wr_rs, wr_data, lcd_d_in,
        input  full, busy, ovf, lcd_e, lcd_rw, lcd_rs, lcd_d_out, lcd_d_oe
    );

    modport slave (
        input  wr_stb, wr_rs, wr_data, lcd_d_in,
        output full, busy, ovf, lcd_e, lcd_rw, lcd_rs, lcd_d_out, lcd_d_oe
    );
endinterface

// File: rtl/lcd1602_bus_ctrl.sv
// Autonomous HD44780/LCD1602 write sequencer fed by a small {rs,data} FIFO.
// Define LCD_BUSY_POLL_EN to replace the fixed post-write wait with a busy-flag poll.
module lcd1602_bus_ctrl #(
    parameter int DEPTH   = 4,
    parameter int T_AS    = 2,
    parameter int T_PW    = 12,
    parameter int T_H     = 2,
    parameter int T_EXEC  = 1000,
    parameter int T_CLEAR = 36500
) (
    input  logic              in_clock,
    input  logic              rst,
    lcd1602_bus_ctrl_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [15:0] AS_LD    = 16'(T_AS - 1);
    localparam logic [15:0] PW_LD    = 16'(T_PW - 1);
    localparam logic [15:0] H_LD     = 16'(T_H - 1);
    localparam logic [15:0] EXEC_LD  = 16'(T_EXEC - 1);
    localparam logic [15:0] CLEAR_LD = 16'(T_CLEAR - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT,
        S_POLL_SETUP,
        S_POLL_PULSE,
        S_POLL_HOLD
    } state_e;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } entry_t;

    // ------------------------------------------------------------------ FIFO
    entry_t        mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          full_q, full_d;
    logic          busy_q, busy_d;
    logic          ovf_q;
    logic          push, pop, fifo_nempty;

    state_e        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    entry_t        hold_q, hold_d;

    assign fifo_nempty = (wr_ptr_q != rd_ptr_q);
    assign push        = bus.wr_stb && !full_q;
    assign pop         = (state_q == S_IDLE) && fifo_nempty;

    assign wr_ptr_d = push ? wr_ptr_q + (AW + 1)'(1) : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + (AW + 1)'(1) : rd_ptr_q;
    assign full_d   = ((wr_ptr_d - rd_ptr_d) == (AW + 1)'(DEPTH));
    assign busy_d   = (wr_ptr_d != rd_ptr_d) || (state_d != S_IDLE);

    // NOTE: storage array has no reset; emptiness is defined by the pointers alone.
    always_ff @(posedge in_clock) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= '{rs: bus.wr_rs, data: bus.wr_data};
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge in_clock or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_q | (bus.wr_stb & full_q);
        end
    end

    // ------------------------------------------------------------------ FSM
    logic cnt_done;
    logic is_clear;

    assign cnt_done = (cnt_q == '0);
    // Clear display / return home need the long execution time.
    assign is_clear = !hold_q.rs && (hold_q.data >= 8'h01) && (hold_q.data <= 8'h03);

`ifdef LCD_BUSY_POLL_EN
    logic        bf_q, bf_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
`endif

    always_ff @(posedge in_clock or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hold_q     <= '0;
`ifdef LCD_BUSY_POLL_EN
            bf_q       <= 1'b0;
            poll_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
`ifdef LCD_BUSY_POLL_EN
            bf_q       <= bf_d;
            poll_cnt_q <= poll_cnt_d;
`endif
        end
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
`ifdef LCD_BUSY_POLL_EN
        bf_d       = bf_q;
        poll_cnt_d = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (fifo_nempty) begin
                    hold_d  = mem_q[rd_ptr_q[AW-1:0]];
                    state_d = S_SETUP;
                    cnt_d   = AS_LD;
                end
            end
            S_SETUP: begin
                if (cnt_done) begin
                    state_d = S_PULSE;
                    cnt_d   = PW_LD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_PULSE: begin
                if (cnt_done) begin
                    state_d = S_HOLD;
                    cnt_d   = H_LD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_HOLD: begin
                if (cnt_done) begin
`ifdef LCD_BUSY_POLL_EN
                    state_d    = S_POLL_SETUP;
                    cnt_d      = AS_LD;
                    poll_cnt_d = '0;
`else
                    state_d = S_WAIT;
                    cnt_d   = is_clear ? CLEAR_LD : EXEC_LD;
`endif
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_WAIT: begin
                if (cnt_done) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`ifdef LCD_BUSY_POLL_EN
            S_POLL_SETUP: begin
                if (cnt_done) begin
                    state_d = S_POLL_PULSE;
                    cnt_d   = PW_LD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_POLL_PULSE: begin
                if (cnt_done) begin
                    bf_d    = bus.lcd_d_in[7];
                    state_d = S_POLL_HOLD;
                    cnt_d   = H_LD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_POLL_HOLD: begin
                // The total poll budget stops a missing LCD from hanging the block.
                if (cnt_done) begin
                    if (bf_q && (poll_cnt_q < CLEAR_LD)) begin
                        state_d = S_POLL_SETUP;
                        cnt_d   = AS_LD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        bus.lcd_e     = 1'b0;
        bus.lcd_rw    = 1'b0;
        bus.lcd_rs    = hold_q.rs;
        bus.lcd_d_out = hold_q.data;
        bus.lcd_d_oe  = 1'b0;
        unique case (state_q)
            S_SETUP, S_HOLD: begin
                bus.lcd_d_oe = 1'b1;
            end
            S_PULSE: begin
                bus.lcd_d_oe = 1'b1;
                bus.lcd_e    = 1'b1;
            end
`ifdef LCD_BUSY_POLL_EN
            S_POLL_SETUP, S_POLL_HOLD: begin
                bus.lcd_rs = 1'b0;
                bus.lcd_rw = 1'b1;
            end
            S_POLL_PULSE: begin
                bus.lcd_rs = 1'b0;
                bus.lcd_rw = 1'b1;
                bus.lcd_e  = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    assign bus.full = full_q;
    assign bus.busy = busy_q;
    assign bus.ovf  = ovf_q;

endmodule
